// File: rtl/lock_code_programmer_if.sv
// Handshake bundle between the code programmer and its surroundings.
// The master side drives button/program pulses; the slave side returns the stored code and status.
interface lock_code_programmer_if #(
  parameter int CODE_LEN = 4
);
  logic                    prog_req;
  logic [3:0]              btn_pulse;
  logic [2*CODE_LEN-1:0]   code_out;
  logic                    code_update;
  logic                    prog_err;
  logic                    busy;
  logic [3:0]              digit_cnt;
  logic [6:0]              segment;

  modport master (
    output prog_req, btn_pulse,
    input  code_out, code_update, prog_err, busy, digit_cnt, segment
  );

  modport slave (
    input  prog_req, btn_pulse,
    output code_out, code_update, prog_err, busy, digit_cnt, segment
  );
endinterface

// File: rtl/lock_code_programmer.sv
// Captures a new lock combination (enter + confirm) and publishes it on a match; drives a status digit.
// Optional entry inactivity timeout is built only when PROG_TIMEOUT_EN is defined.
module lock_code_programmer #(
  parameter int                    CODE_LEN       = 4,
  parameter logic [2*CODE_LEN-1:0] DEFAULT_CODE   = 8'hE4,
  parameter int                    TIMEOUT_CYCLES = 100000000
) (
  input  logic                  clk,
  input  logic                  rst,
  lock_code_programmer_if.slave bus
);
  localparam int W = 2 * CODE_LEN;

  localparam logic [6:0] SEG_L = 7'b1110001;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_P = 7'b0011000;
  localparam logic [6:0] SEG_C = 7'b0110001;

  if (CODE_LEN < 2 || CODE_LEN > 8) begin : g_bad_len
    $error("CODE_LEN must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_ENTER, S_CONFIRM, S_CHECK, S_COMMIT, S_ERROR
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [W-1:0]   r_entry_a, r_entry_b, r_code;
  logic [3:0]     r_digit_cnt;
  logic           r_err_flag, r_code_update, r_prog_err;
  logic [6:0]     r_segment;

  logic           w_onehot, w_entry_st, w_accept, w_last, w_restart, w_timeout;
  logic [1:0]     w_idx;

  always_comb begin
    w_onehot = 1'b1;
    w_idx    = 2'd0;
    case (bus.btn_pulse)
      4'b0001: w_idx = 2'd0;
      4'b0010: w_idx = 2'd1;
      4'b0100: w_idx = 2'd2;
      4'b1000: w_idx = 2'd3;
      default: w_onehot = 1'b0;
    endcase
  end

  // prog_req outranks a same-cycle press, so the press is never counted
  assign w_entry_st = (r_state == S_ENTER) || (r_state == S_CONFIRM);
  assign w_accept   = w_entry_st && w_onehot && !bus.prog_req;
  assign w_last     = w_accept && (r_digit_cnt == 4'(CODE_LEN - 1));
  assign w_restart  = bus.prog_req && (r_state inside {S_IDLE, S_ENTER, S_CONFIRM, S_CHECK});

`ifdef PROG_TIMEOUT_EN
  localparam int            TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] r_tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst || w_restart || w_accept || !w_entry_st) r_tmo_cnt <= '0;
    else                                             r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  assign w_timeout = w_entry_st && !w_accept && (r_tmo_cnt == TMO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_restart) begin
      w_state_nxt = S_ENTER;
    end else begin
      case (r_state)
        S_ENTER:   if (w_timeout) w_state_nxt = S_ERROR;
                   else if (w_last) w_state_nxt = S_CONFIRM;
        S_CONFIRM: if (w_timeout) w_state_nxt = S_ERROR;
                   else if (w_last) w_state_nxt = S_CHECK;
        S_CHECK:   w_state_nxt = (r_entry_a == r_entry_b) ? S_COMMIT : S_ERROR;
        S_COMMIT:  w_state_nxt = S_IDLE;
        S_ERROR:   w_state_nxt = S_IDLE;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Pulses and the new code are registered on entry to COMMIT/ERROR so they line up in that cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_entry_a     <= '0;
      r_entry_b     <= '0;
      r_code        <= DEFAULT_CODE;
      r_digit_cnt   <= 4'd0;
      r_err_flag    <= 1'b0;
      r_code_update <= 1'b0;
      r_prog_err    <= 1'b0;
      r_segment     <= SEG_L;
    end else begin
      r_code_update <= (w_state_nxt == S_COMMIT);
      r_prog_err    <= (w_state_nxt == S_ERROR);
      if (w_state_nxt == S_COMMIT) r_code <= r_entry_a;

      if (w_restart) begin
        r_entry_a   <= '0;
        r_entry_b   <= '0;
        r_digit_cnt <= 4'd0;
        r_err_flag  <= 1'b0;
      end else begin
        if (w_state_nxt == S_ERROR) r_err_flag <= 1'b1;
        if (w_accept) begin
          if (r_state == S_ENTER) r_entry_a <= {r_entry_a[W-3:0], w_idx};
          else                    r_entry_b <= {r_entry_b[W-3:0], w_idx};
          r_digit_cnt <= w_last ? 4'd0 : r_digit_cnt + 4'd1;
        end
      end

      case (r_state)
        S_IDLE:                     r_segment <= r_err_flag ? SEG_E : SEG_L;
        S_ENTER:                    r_segment <= SEG_P;
        S_CONFIRM, S_CHECK, S_COMMIT: r_segment <= SEG_C;
        default:                    r_segment <= SEG_E;
      endcase
    end
  end

  assign bus.code_out    = r_code;
  assign bus.code_update = r_code_update;
  assign bus.prog_err    = r_prog_err;
  assign bus.busy        = w_entry_st;
  assign bus.digit_cnt   = r_digit_cnt;
  assign bus.segment     = r_segment;
endmodule

// File: tb/tb_lock_code_programmer.sv
// Randomized and directed bench for lock_code_programmer against a sequence-level reference model.
module tb_lock_code_programmer;
  localparam int         L     = 4;
  localparam logic [7:0] DEF   = 8'hE4;
  localparam logic [6:0] SEG_L = 7'b1110001;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_P = 7'b0011000;
  localparam logic [6:0] SEG_C = 7'b0110001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] model_code;
  logic [3:0] junk_tab [6] = '{4'h0, 4'h3, 4'h5, 4'hA, 4'hC, 4'hF};

  lock_code_programmer_if #(.CODE_LEN(L)) bus();

  lock_code_programmer #(
    .CODE_LEN(L), .DEFAULT_CODE(DEF), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic prog();
    bus.prog_req = 1'b1;
    cyc();
    bus.prog_req = 1'b0;
  endtask

  task automatic press(input int d);
    bus.btn_pulse = 4'b0001 << d;
    cyc();
    bus.btn_pulse = 4'b0000;
  endtask

  // gap < 0 selects random gaps filled with ignored zero/multi-hot pulses
  task automatic enter_pass(input logic [7:0] c, input int gap, input bit second);
    for (int i = 0; i < L; i++) begin
      int g;
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      for (int k = 0; k < g; k++) begin
        bus.btn_pulse = (gap < 0) ? junk_tab[$urandom_range(0, 5)] : 4'b0000;
        cyc();
      end
      bus.btn_pulse = 4'b0000;
      press(int'(c[2*(L-1-i) +: 2]));
      if (i == 0) begin
        check(second ? "seg_confirm" : "seg_enter", 32'(bus.segment), second ? 32'(SEG_C) : 32'(SEG_P));
        check("busy_in_pass", 32'(bus.busy), 32'd1);
      end
      if (!second || i < L - 1) check("digit_cnt", 32'(bus.digit_cnt), 32'((i + 1) % L));
    end
  endtask

  task automatic program_and_check(input logic [7:0] a, input logic [7:0] b, input int gap);
    bit eq;
    eq = (a == b);
    prog();
    enter_pass(a, gap, 1'b0);
    enter_pass(b, gap, 1'b1);
    check("busy_in_check", 32'(bus.busy), 32'd0);
    check("update_early", 32'(bus.code_update), 32'd0);
    check("err_early", 32'(bus.prog_err), 32'd0);
    cyc();
    if (eq) model_code = a;
    check("code_update", 32'(bus.code_update), 32'(eq));
    check("prog_err", 32'(bus.prog_err), 32'(!eq));
    check("code_out", 32'(bus.code_out), 32'(model_code));
    cyc();
    check("update_one_cycle", 32'(bus.code_update), 32'd0);
    check("err_one_cycle", 32'(bus.prog_err), 32'd0);
    cyc();
    check("seg_after", 32'(bus.segment), eq ? 32'(SEG_L) : 32'(SEG_E));
  endtask

  initial begin
    logic [7:0] a, b;
    int         j, early, seen;
    bus.prog_req  = 1'b0;
    bus.btn_pulse = 4'b0000;
    model_code    = DEF;

    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    check("rst_code", 32'(bus.code_out), 32'(DEF));
    check("rst_seg", 32'(bus.segment), 32'(SEG_L));
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_update", 32'(bus.code_update), 32'd0);
    check("rst_err", 32'(bus.prog_err), 32'd0);
    check("rst_cnt", 32'(bus.digit_cnt), 32'd0);

    // Presses while idle are ignored
    press(1);
    check("idle_ignore_cnt", 32'(bus.digit_cnt), 32'd0);
    check("idle_ignore_busy", 32'(bus.busy), 32'd0);

    // Mismatching confirmation leaves the default code in place
    program_and_check(8'h1B, 8'h1A, 5);
    repeat (10) cyc();
    check("seg_err_sticky", 32'(bus.segment), 32'(SEG_E));
    check("code_kept", 32'(bus.code_out), 32'(DEF));

    program_and_check(8'h1B, 8'h1B, 5);

    for (int n = 0; n < 24; n++) begin
      a = 8'($urandom);
      b = a;
      if ($urandom_range(0, 2) == 0) begin
        j = int'($urandom_range(0, L - 1));
        b[2*j +: 2] = 2'(a[2*j +: 2] + 2'(1 + $urandom_range(0, 2)));
      end
      program_and_check(a, b, -1);
    end

    // Invalid pulses and prog_req priority
    prog();
    press(0);
    press(1);
    check("two_digits", 32'(bus.digit_cnt), 32'd2);
    bus.btn_pulse = 4'b0011;
    cyc();
    check("multi_hot_ignored", 32'(bus.digit_cnt), 32'd2);
    bus.btn_pulse = 4'b0000;
    cyc();
    check("zero_ignored", 32'(bus.digit_cnt), 32'd2);
    bus.prog_req  = 1'b1;
    bus.btn_pulse = 4'b0001;
    cyc();
    bus.prog_req  = 1'b0;
    bus.btn_pulse = 4'b0000;
    check("restart_cnt", 32'(bus.digit_cnt), 32'd0);
    check("restart_busy", 32'(bus.busy), 32'd1);
    cyc();
    check("restart_seg", 32'(bus.segment), 32'(SEG_P));

`ifdef PROG_TIMEOUT_EN
    prog();
    press(2);
    early = 0;
    for (int k = 0; k < 15; k++) begin
      cyc();
      if (bus.prog_err) early++;
    end
    cyc();
    check("timeout_not_early", 32'(early), 32'd0);
    check("timeout_err", 32'(bus.prog_err), 32'd1);
    check("timeout_busy", 32'(bus.busy), 32'd0);
    check("timeout_code", 32'(bus.code_out), 32'(model_code));
    cyc();
    cyc();
    check("timeout_seg", 32'(bus.segment), 32'(SEG_E));
`else
    prog();
    press(2);
    seen = 0;
    for (int k = 0; k < 1000; k++) begin
      cyc();
      if (bus.prog_err) seen++;
    end
    check("no_timeout_err", 32'(seen), 32'd0);
    check("no_timeout_busy", 32'(bus.busy), 32'd1);
    check("no_timeout_cnt", 32'(bus.digit_cnt), 32'd1);
`endif

    // Reset mid-entry discards the programmed code
    program_and_check(8'h1B, 8'h1B, 1);
    prog();
    press(3);
    press(0);
    press(2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    model_code = DEF;
    check("midrst_code", 32'(bus.code_out), 32'(model_code));
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_cnt", 32'(bus.digit_cnt), 32'd0);
    check("midrst_seg", 32'(bus.segment), 32'(SEG_L));
    press(0);
    check("midrst_idle", 32'(bus.digit_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
